// File: rtl/alu_ctrl_mdu.sv
// EX-stage ALU controller with an iterative multiply/divide unit and HI/LO registers.
// Define MDU_DIV_EN to build the restoring divider (div/divu); otherwise those functs are illegal.
module alu_ctrl_mdu #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [5:0]        funct_i,
    input  logic [2:0]        ALUOp_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    output logic [CTRL_W-1:0] ALUCtrl_o,
    output logic              illegal_o,
    output logic              hilo_sel_o,
    output logic [DATA_W-1:0] hilo_o,
    output logic              stall_o,
    output logic              busy_o
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]          state;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   lo_q;
    logic [DATA_W-1:0]   acc_hi;
    logic [DATA_W-1:0]   acc_lo;
    logic [DATA_W-1:0]   opb;
    logic                neg_q;

    logic [3:0]          code;
    logic                is_mdu;
    logic                is_mf;
    logic                is_signed_op;
    logic                issue;

    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] step_next;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   fin_hi;
    logic [DATA_W-1:0]   fin_lo;

`ifdef MDU_DIV_EN
    logic                is_div_op;
    logic                op_div;
    logic                neg_r;
    logic                div0;
    logic [DATA_W:0]     div_shift;
    logic                div_ok;
    logic [DATA_W-1:0]   div_rem;
`endif

    function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] v);
        return ~v + 1'b1;
    endfunction

    function automatic logic [2*DATA_W-1:0] neg_2w(input logic [2*DATA_W-1:0] v);
        return ~v + 1'b1;
    endfunction

    function automatic logic [DATA_W-1:0] abs_w(input logic [DATA_W-1:0] v, input logic sgn);
        return (sgn && v[DATA_W-1]) ? neg_w(v) : v;
    endfunction

    always_comb begin
        code         = 4'd15;
        is_mdu       = 1'b0;
        is_mf        = 1'b0;
        is_signed_op = 1'b0;
`ifdef MDU_DIV_EN
        is_div_op    = 1'b0;
`endif
        case (ALUOp_i)
            3'd0: begin
                case (funct_i)
                    6'd32: code = 4'd2;
                    6'd34: code = 4'd6;
                    6'd36: code = 4'd0;
                    6'd37: code = 4'd1;
                    6'd42: code = 4'd7;
                    6'd24: begin code = 4'd2; is_mdu = 1'b1; is_signed_op = 1'b1; end
                    6'd25: begin code = 4'd2; is_mdu = 1'b1; end
`ifdef MDU_DIV_EN
                    6'd26: begin code = 4'd2; is_mdu = 1'b1; is_div_op = 1'b1; is_signed_op = 1'b1; end
                    6'd27: begin code = 4'd2; is_mdu = 1'b1; is_div_op = 1'b1; end
`endif
                    6'd16, 6'd18: begin code = 4'd8; is_mf = 1'b1; end
                    default: code = 4'd15;
                endcase
            end
            3'd1: code = 4'd6;
            3'd2: code = 4'd2;
            3'd3: code = 4'd7;
            3'd4: code = 4'd0;
            3'd5: code = 4'd1;
            default: code = 4'd15;
        endcase
    end

    assign ALUCtrl_o  = CTRL_W'(code);
    assign illegal_o  = valid_i && (code == 4'd15);
    assign hilo_sel_o = is_mf;
    assign hilo_o     = (funct_i == 6'd16) ? hi_q : lo_q;

    // Reset is folded in so a held MDU instruction cannot raise stall while reset is asserted.
    assign issue   = rst_i && valid_i && is_mdu && (state == ST_IDLE);
    assign stall_o = issue || (state == ST_BUSY);
    assign busy_o  = (state != ST_IDLE);

    // Iteration step: shift-add multiply, restoring divide (quotient shifts into acc_lo)
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
        step_next = {mul_sum, acc_lo[DATA_W-1:1]};
`ifdef MDU_DIV_EN
        div_shift = {acc_hi, acc_lo[DATA_W-1]};
        div_ok    = (div_shift >= {1'b0, opb});
        div_rem   = div_ok ? (div_shift[DATA_W-1:0] - opb) : div_shift[DATA_W-1:0];
        if (op_div)
            step_next = {div_rem, acc_lo[DATA_W-2:0], div_ok};
`endif
    end

    // Sign fix-up on the final step; divide by zero leaves |dividend| which the dividend sign restores.
    always_comb begin
        prod   = neg_q ? neg_2w(step_next) : step_next;
        fin_hi = prod[2*DATA_W-1:DATA_W];
        fin_lo = prod[DATA_W-1:0];
`ifdef MDU_DIV_EN
        if (op_div) begin
            fin_lo = div0 ? '1 : (neg_q ? neg_w(step_next[DATA_W-1:0]) : step_next[DATA_W-1:0]);
            fin_hi = neg_r ? neg_w(step_next[2*DATA_W-1:DATA_W]) : step_next[2*DATA_W-1:DATA_W];
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
            cnt   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (issue) begin
                        state <= ST_BUSY;
                        cnt   <= '0;
                    end
                end
                ST_BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= ST_DONE;
                        hi_q  <= fin_hi;
                        lo_q  <= fin_lo;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Operand datapath: magnitudes latched at issue, then iterated while busy
    always_ff @(posedge clk_i) begin
        if (issue) begin
            acc_hi <= '0;
            acc_lo <= abs_w(src1_i, is_signed_op);
            opb    <= abs_w(src2_i, is_signed_op);
            neg_q  <= is_signed_op && (src1_i[DATA_W-1] ^ src2_i[DATA_W-1]);
`ifdef MDU_DIV_EN
            op_div <= is_div_op;
            neg_r  <= is_div_op && is_signed_op && src1_i[DATA_W-1];
            div0   <= (src2_i == '0);
`endif
        end else if (state == ST_BUSY) begin
            {acc_hi, acc_lo} <= step_next;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Self-checking bench for alu_ctrl_mdu: decode table, MDU scoreboard, reset abort, optional divider.
module tb_alu_ctrl_mdu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid;
    logic [5:0]   funct;
    logic [2:0]   aluop;
    logic [W-1:0] src1;
    logic [W-1:0] src2;
    logic [3:0]   alu_ctrl;
    logic         illegal;
    logic         hilo_sel;
    logic [W-1:0] hilo;
    logic         stall;
    logic         busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0] aluop;
        logic [5:0] funct;
        logic       valid;
        logic [3:0] ctrl;
        logic       ill;
        logic       sel;
    } dec_vec_t;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } hilo_t;

    dec_vec_t dv[$];
    hilo_t    sb[$];

    always #5 clk = ~clk;

    alu_ctrl_mdu #(.DATA_W(W), .CTRL_W(4)) dut (
        .clk_i(clk),
        .rst_i(rst_n),
        .valid_i(valid),
        .funct_i(funct),
        .ALUOp_i(aluop),
        .src1_i(src1),
        .src2_i(src2),
        .ALUCtrl_o(alu_ctrl),
        .illegal_o(illegal),
        .hilo_sel_o(hilo_sel),
        .hilo_o(hilo),
        .stall_o(stall),
        .busy_o(busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic pop_expected(input string name, output hilo_t e);
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty, got 0 entries, expected 1", name);
            e.hi = '0;
            e.lo = '0;
        end else begin
            e = sb.pop_front();
        end
    endtask

    task automatic read_hilo(input string name, input hilo_t e);
        funct = 6'd16;
        #1;
        check({name, " hi"}, hilo, e.hi);
        funct = 6'd18;
        #1;
        check({name, " lo"}, hilo, e.lo);
    endtask

    // Issue an MDU op, count stall cycles, then read HI/LO in the DONE cycle.
    task automatic run_mdu(input string name, input logic [5:0] f, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo);
        hilo_t e;
        int    cnt;
        e.hi = ehi;
        e.lo = elo;
        sb.push_back(e);
        @(negedge clk);
        valid = 1'b1; aluop = 3'd0; funct = f; src1 = a; src2 = b;
        #1;
        cnt = 0;
        while (stall && cnt < 200) begin
            cnt++;
            @(negedge clk);
            #1;
        end
        check({name, " stall cycles"}, 64'(cnt), 64'(W + 1));
        check({name, " busy in done"}, busy, 1'b1);
        check({name, " no reissue in done"}, stall, 1'b0);
        pop_expected(name, e);
        read_hilo(name, e);
        valid = 1'b0;
        @(negedge clk);
        #1;
        check({name, " idle after done"}, busy, 1'b0);
    endtask

    initial begin
        hilo_t e;
        int    cnt;

        rst_n = 1'b0; valid = 1'b0; aluop = 3'd0; funct = 6'd0; src1 = '0; src2 = '0;

        dv.push_back('{3'd0, 6'd32, 1'b1, 4'd2,  1'b0, 1'b0});
        dv.push_back('{3'd0, 6'd34, 1'b1, 4'd6,  1'b0, 1'b0});
        dv.push_back('{3'd0, 6'd36, 1'b1, 4'd0,  1'b0, 1'b0});
        dv.push_back('{3'd0, 6'd37, 1'b1, 4'd1,  1'b0, 1'b0});
        dv.push_back('{3'd0, 6'd42, 1'b1, 4'd7,  1'b0, 1'b0});
        dv.push_back('{3'd1, 6'd0,  1'b1, 4'd6,  1'b0, 1'b0});
        dv.push_back('{3'd2, 6'd0,  1'b1, 4'd2,  1'b0, 1'b0});
        dv.push_back('{3'd3, 6'd0,  1'b1, 4'd7,  1'b0, 1'b0});
        dv.push_back('{3'd4, 6'd0,  1'b1, 4'd0,  1'b0, 1'b0});
        dv.push_back('{3'd5, 6'd0,  1'b1, 4'd1,  1'b0, 1'b0});
        dv.push_back('{3'd6, 6'd0,  1'b1, 4'd15, 1'b1, 1'b0});
        dv.push_back('{3'd7, 6'd0,  1'b1, 4'd15, 1'b1, 1'b0});
        dv.push_back('{3'd6, 6'd0,  1'b0, 4'd15, 1'b0, 1'b0});
        dv.push_back('{3'd0, 6'd16, 1'b1, 4'd8,  1'b0, 1'b1});
        dv.push_back('{3'd0, 6'd18, 1'b1, 4'd8,  1'b0, 1'b1});
        dv.push_back('{3'd0, 6'd63, 1'b1, 4'd15, 1'b1, 1'b0});
        dv.push_back('{3'd0, 6'd63, 1'b0, 4'd15, 1'b0, 1'b0});
        dv.push_back('{3'd0, 6'd24, 1'b0, 4'd2,  1'b0, 1'b0});
        dv.push_back('{3'd0, 6'd25, 1'b0, 4'd2,  1'b0, 1'b0});

        // Reset state
        #2;
        check("reset stall", stall, 1'b0);
        check("reset busy", busy, 1'b0);
        e.hi = '0; e.lo = '0;
        read_hilo("reset", e);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (dv[i]) begin
            @(negedge clk);
            aluop = dv[i].aluop; funct = dv[i].funct; valid = dv[i].valid;
            #1;
            check($sformatf("dec%0d ctrl", i), alu_ctrl, dv[i].ctrl);
            check($sformatf("dec%0d illegal", i), illegal, dv[i].ill);
            check($sformatf("dec%0d hilo_sel", i), hilo_sel, dv[i].sel);
            check($sformatf("dec%0d stall", i), stall, 1'b0);
        end
        valid = 1'b0;

        run_mdu("mult",        6'd24, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_mdu("multu",       6'd25, 32'd7,          32'hFFFF_FFFD, 32'h0000_0006, 32'hFFFF_FFEB);
        run_mdu("mult_minmin", 6'd24, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_mdu("multu_max",   6'd25, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
`ifdef MDU_DIV_EN
        run_mdu("div_neg",     6'd26, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_mdu("div_negdiv",  6'd26, 32'd7,          32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run_mdu("div_zero",    6'd26, 32'd5,          32'd0,         32'h0000_0005, 32'hFFFF_FFFF);
        run_mdu("div_ovf",     6'd26, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_mdu("divu",        6'd27, 32'd100,        32'd7,         32'h0000_0002, 32'h0000_000E);
`endif

        // mflo arriving in EX while the mult is still iterating
        e.hi = 32'hFFFF_FFFF; e.lo = 32'hFFFF_FFF4;
        sb.push_back(e);
        @(negedge clk);
        valid = 1'b1; aluop = 3'd0; funct = 6'd24; src1 = 32'd3; src2 = 32'hFFFF_FFFC;
        #1;
        check("mflo issue stall", stall, 1'b1);
        cnt = 1;
        @(negedge clk);
        funct = 6'd18;
        #1;
        while (stall && cnt < 200) begin
            cnt++;
            @(negedge clk);
            #1;
        end
        check("mflo stall cycles", 64'(cnt), 64'(W + 1));
        pop_expected("mflo", e);
        check("mflo hilo_sel", hilo_sel, 1'b1);
        check("mflo value", hilo, e.lo);
        check("mflo busy in done", busy, 1'b1);
        valid = 1'b0;
        @(negedge clk);
        #1;
        check("mflo idle after done", busy, 1'b0);

        // Reset pulse in the middle of a mult
        @(negedge clk);
        valid = 1'b1; aluop = 3'd0; funct = 6'd24; src1 = 32'd7; src2 = 32'hFFFF_FFFD;
        repeat (10) @(negedge clk);
        #1;
        check("abort busy before reset", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort stall", stall, 1'b0);
        check("abort busy", busy, 1'b0);
        e.hi = '0; e.lo = '0;
        read_hilo("abort", e);
        valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_mdu("mult_after_reset", 6'd24, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

`ifndef MDU_DIV_EN
        // Divider absent: div/divu are illegal and leave HI/LO untouched
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            valid = 1'b1; aluop = 3'd0; funct = 6'(26 + k); src1 = 32'd100; src2 = 32'd7;
            #1;
            check($sformatf("nodiv%0d ctrl", k), alu_ctrl, 4'd15);
            check($sformatf("nodiv%0d illegal", k), illegal, 1'b1);
            check($sformatf("nodiv%0d stall", k), stall, 1'b0);
            @(negedge clk);
            #1;
            check($sformatf("nodiv%0d busy", k), busy, 1'b0);
            e.hi = 32'hFFFF_FFFF; e.lo = 32'hFFFF_FFEB;
            read_hilo($sformatf("nodiv%0d", k), e);
            valid = 1'b0;
        end
`endif

        check("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_mdu.md
Name: alu_ctrl_mdu

Overview:
- Parametrised successor to the combinational ALU controller for the pipelined MIPS core. Sits in the EX stage.
- Decodes ALUOp/funct into the ALU operation code, exactly as before.
- Also owns an iterative multiply/divide unit (MDU) with HI/LO registers and mfhi/mflo support.
- Drives a stall to the pipeline while a multi-cycle operation is in flight.
- Unknown encodings yield a defined code plus an illegal flag; no latches.

Parameters:
- DATA_W, 32, operand and HI/LO width; even, >=8.
- CTRL_W, 4, ALUCtrl_o width; >=4, upper bits zero for all defined codes.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-low reset
- valid_i  in  1  EX-stage instruction is valid
- funct_i  in  6  R-type function field
- ALUOp_i  in  3  main-control ALU op class
- src1_i  in  DATA_W  rs operand
- src2_i  in  DATA_W  rt operand
- ALUCtrl_o  out  CTRL_W  ALU operation code
- illegal_o  out  1  unknown ALUOp/funct while valid_i
- hilo_sel_o  out  1  EX result comes from hilo_o, not the ALU
- hilo_o  out  DATA_W  HI (mfhi) or LO (mflo)
- stall_o  out  1  freeze IF/ID/EX; EX holds its instruction
- busy_o  out  1  MDU state != IDLE

Behaviour:
- Reset is asynchronous, active-low:
  - state=IDLE, HI=LO=0, counter=0.
  - stall_o=0, busy_o=0; all outputs are combinational from these.
  - A reset mid-operation aborts it with no HI/LO update.
- ALUOp decode (combinational):
  - 0 = R-type, see funct below.
  - 1 = sub (6), for beq.
  - 2 = add (2), for addi/lw/sw.
  - 3 = slt (7), for slti.
  - 4 = and (0).
  - 5 = or (1).
  - 6, 7 = illegal.
- R-type funct decode:
  - 32 add→2, 34 sub→6, 36 and→0, 37 or→1, 42 slt→7.
  - 24 mult, 25 multu, 26 div, 27 divu→2; these are MDU ops and the ALU result is unused.
  - 16 mfhi, 18 mflo→8 (pass) with hilo_sel_o=1.
  - Any other funct→15.
- illegal_o=1 iff valid_i and the code resolves to 15. There is no other side effect.
- hilo_o=HI for mfhi, LO otherwise.
- MDU FSM states: IDLE, BUSY, DONE.
  - IDLE→BUSY: valid_i & MDU op. In that same cycle:
    - Latch operand magnitudes; signed ops take two's-complement abs.
    - Latch the result signs and the op type; counter=0.
    - stall_o=1 combinationally.
  - BUSY: one iteration per cycle; counter++; stall_o=1.
    - Multiply: shift-add, producing the 2*DATA_W product.
    - Divide: restoring, one quotient bit per cycle.
    - After DATA_W iterations (counter==DATA_W-1) → DONE.
    - On that transition, write HI/LO:
      - Signed mult negates the product if the operand signs differ.
      - Signed div: quotient sign = sign1^sign2; remainder takes the sign of the dividend.
      - mult: HI=upper half, LO=lower half.
      - div: LO=quotient, HI=remainder.
  - DONE: stall_o=0, so the pipeline advances past the held MDU instruction. A new issue is suppressed this cycle. DONE→IDLE.
- Total stall for an MDU op: DATA_W+1 cycles. HI/LO are readable from the DONE cycle.
- mfhi/mflo while state is BUSY, or in the issue cycle: stall_o=1 until DONE. It then reads the new HI/LO.
- Divide by zero: no trap. LO=all ones; HI=dividend as given (signed input, unmodified).
- Signed overflow case (most-negative / -1): LO=most-negative, HI=0.
- valid_i=0: no issue, illegal_o=0. ALUCtrl_o is still decoded.

Optional Feature:
- Macro: MDU_DIV_EN.
- Defined: div/divu are supported as described above.
- Undefined:
  - funct 26/27 decode to ALUCtrl 15 with illegal_o=1.
  - No stall and no HI/LO change.
  - The divider datapath is not instantiated. Multiply behaviour is unchanged.

Test Plan:
- Decode sweep: ALUOp=0 with funct 32/34/36/37/42 → ALUCtrl 2/6/0/1/7. ALUOp 1/2/3/4/5 → 6/2/7/0/1. ALUOp=6 with valid_i=1 → 15 and illegal_o=1.
- mult with src1=7, src2=0xFFFFFFFD → stall_o high 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB. multu with the same operands → HI=0x00000006, LO=0xFFFFFFEB.
- div with src1=0xFFFFFFF9 (-7), src2=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. div by 0 with src1=5 → LO=0xFFFFFFFF, HI=5.
- mflo issued one cycle after mult issue → stall_o held through BUSY. In DONE, hilo_sel_o=1 and hilo_o equals the new LO. No second mult issue while the mult is held through DONE.
- rst_i pulsed low during cycle 10 of BUSY → immediately state=IDLE, stall_o=0, HI=LO=0. A following mult completes normally.
- Build without MDU_DIV_EN: funct 26 with valid_i=1 → ALUCtrl 15, illegal_o=1, stall_o=0, HI/LO unchanged.
